// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, optionally glitch-filters them,
// decodes Gray-code steps into a signed position, and reports per-window velocity.
// Build option: define QDEC_FILTER_EN to enable the FILTER_CYCLES stability filter.
//
// Decoder FSM (state = last accepted {A,B} level)
//   state | meaning
//   ST_00 | A=0 B=0
//   ST_01 | A=0 B=1 (one step forward of ST_00)
//   ST_11 | A=1 B=1
//   ST_10 | A=1 B=0 (one step forward of ST_11)
module quad_encoder_decoder #(
    parameter int COUNT_WIDTH   = 32,
    parameter int SAMPLE_CYCLES = 1000000,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enc_a,
    input  logic                          enc_b,
    input  logic                          clear,
    input  logic                          invert_dir,
    input  logic                          err_clear,
    output logic signed [COUNT_WIDTH-1:0] position,
    output logic signed [15:0]            velocity,
    output logic                          vel_valid,
    output logic                          direction,
    output logic                          error
);

    localparam int WIN_W     = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int ACC_W_MIN = $clog2(SAMPLE_CYCLES + 1) + 2;
    localparam int ACC_W     = (ACC_W_MIN > 17) ? ACC_W_MIN : 17;
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] VEL_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] VEL_MIN  = -ACC_W'(32768);

    typedef enum logic [1:0] {
        ST_00 = 2'b00,
        ST_01 = 2'b01,
        ST_11 = 2'b11,
        ST_10 = 2'b10
    } gray_state_t;

    logic [1:0]  a_sync;
    logic [1:0]  b_sync;
    logic [1:0]  sync_vld;
    logic [1:0]  ab_sync;
    logic [1:0]  ab_filt;
    logic        init_pending;
    logic        init_d;
    gray_state_t state_q;
    gray_state_t state_d;
    logic signed [1:0] step_raw;
    logic signed [1:0] step;
    logic        illegal;

    logic [WIN_W-1:0]        win_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;

    function automatic gray_state_t fwd_of(input gray_state_t s);
        case (s)
            ST_00:   return ST_01;
            ST_01:   return ST_11;
            ST_11:   return ST_10;
            ST_10:   return ST_00;
            default: return ST_00;
        endcase
    endfunction

    function automatic gray_state_t rev_of(input gray_state_t s);
        case (s)
            ST_00:   return ST_10;
            ST_10:   return ST_11;
            ST_11:   return ST_01;
            ST_01:   return ST_00;
            default: return ST_00;
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > VEL_MAX)      return 16'sh7FFF;
        else if (v < VEL_MIN) return 16'sh8000;
        else                  return v[15:0];
    endfunction

    // Two-flop synchronizers; sync_vld marks when the chain holds post-reset pin data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync   <= 2'b00;
            b_sync   <= 2'b00;
            sync_vld <= 2'b00;
        end else begin
            a_sync   <= {a_sync[0], enc_a};
            b_sync   <= {b_sync[0], enc_b};
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign ab_sync = {a_sync[1], b_sync[1]};

`ifdef QDEC_FILTER_EN
    localparam int FC     = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
    localparam int FCNT_W = $clog2(FC + 1);

    logic [1:0]        filt_q;
    logic [1:0]        cand_q;
    logic [FCNT_W-1:0] fcnt;

    // Accept a new level only after it has been seen unchanged for FC clocks;
    // any other level in between restarts the count. The first sample is taken as-is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 2'b00;
            cand_q <= 2'b00;
            fcnt   <= '0;
        end else if (init_pending) begin
            filt_q <= ab_sync;
            cand_q <= ab_sync;
            fcnt   <= '0;
        end else if (ab_sync == filt_q) begin
            cand_q <= filt_q;
            fcnt   <= '0;
        end else if (ab_sync != cand_q) begin
            cand_q <= ab_sync;
            if (FC == 1) begin
                filt_q <= ab_sync;
                fcnt   <= '0;
            end else begin
                fcnt <= FCNT_W'(1);
            end
        end else if (fcnt >= FCNT_W'(FC - 1)) begin
            filt_q <= ab_sync;
            fcnt   <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign ab_filt = init_pending ? ab_sync : filt_q;
`else
    assign ab_filt = ab_sync;
`endif

    // Decoder state register plus the post-reset initialisation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_00;
            init_pending <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_pending <= init_d;
        end
    end

    // Step decode: forward/reverse neighbour is +/-1, a two-bit jump is illegal.
    always_comb begin
        state_d  = state_q;
        init_d   = init_pending;
        step_raw = 2'sd0;
        illegal  = 1'b0;
        if (init_pending) begin
            if (sync_vld[1]) begin
                state_d = gray_state_t'(ab_filt);
                init_d  = 1'b0;
            end
        end else begin
            state_d = gray_state_t'(ab_filt);
            if (ab_filt == fwd_of(state_q))      step_raw = 2'sd1;
            else if (ab_filt == rev_of(state_q)) step_raw = -2'sd1;
            else if (ab_filt != state_q)         illegal  = 1'b1;
        end
        step = invert_dir ? -step_raw : step_raw;
    end

    assign acc_sum = acc + ACC_W'(step);

    // Position, velocity window, direction and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position  <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
            direction <= 1'b1;
            error     <= 1'b0;
            win_cnt   <= '0;
            acc       <= '0;
        end else begin
            vel_valid <= 1'b0;
            if (clear) begin
                position <= '0;
                acc      <= '0;
                win_cnt  <= '0;
            end else begin
                position <= position + COUNT_WIDTH'(step);
                if (win_cnt == WIN_LAST) begin
                    velocity  <= sat16(acc_sum);
                    vel_valid <= 1'b1;
                    acc       <= '0;
                    win_cnt   <= '0;
                end else begin
                    acc     <= acc_sum;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
            if (step != 2'sd0) direction <= ~step[1];
            if (illegal)        error <= 1'b1;
            else if (err_clear) error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Directed bench for quad_encoder_decoder (COUNT_WIDTH=8, SAMPLE_CYCLES=100).
module tb_quad_encoder_decoder;

    localparam int CW  = 8;
    localparam int SC  = 100;
    localparam int FCY = 4;
`ifdef QDEC_FILTER_EN
    localparam int LAT = 2 + FCY + 1;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset, enc_a, enc_b, clear, invert_dir, err_clear;
    logic signed [CW-1:0] position;
    logic signed [15:0]   velocity;
    logic vel_valid, direction, error;

    int total = 0;
    int bad   = 0;
    logic [1:0] gray [4];
    int gidx;
    int k;
    int n;

    quad_encoder_decoder #(
        .COUNT_WIDTH  (CW),
        .SAMPLE_CYCLES(SC),
        .FILTER_CYCLES(FCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .clear     (clear),
        .invert_dir(invert_dir),
        .err_clear (err_clear),
        .position  (position),
        .velocity  (velocity),
        .vel_valid (vel_valid),
        .direction (direction),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) @(negedge clk);
    endtask

    task automatic step_fwd(input int gap);
        gidx = (gidx + 1) % 4;
        {enc_a, enc_b} = gray[gidx];
        tick(gap);
    endtask

    task automatic step_rev(input int gap);
        gidx = (gidx + 3) % 4;
        {enc_a, enc_b} = gray[gidx];
        tick(gap);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask

    // Waits (bounded) for vel_valid; returns the number of negedges waited.
    task automatic wait_vel(output int waited);
        waited = 0;
        while (vel_valid !== 1'b1 && waited < 250) begin
            tick(1);
            waited++;
        end
        chk("vel_valid_seen", vel_valid, 1);
    endtask

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        gidx = 0;
        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; clear = 1'b0;
        invert_dir = 1'b0; err_clear = 1'b0;
        tick(3);
        chk("rst_position", position, 0);
        chk("rst_velocity", velocity, 0);
        chk("rst_vel_valid", vel_valid, 0);
        chk("rst_direction", direction, 1);
        chk("rst_error", error, 0);
        reset = 1'b0;
        tick(10);
        chk("init_position", position, 0);
        chk("init_error", error, 0);

        // pin-to-position latency
        gidx = 1;
        {enc_a, enc_b} = gray[gidx];
        k = 0;
        while (position != 1 && k < 30) begin
            tick(1);
            k++;
        end
        chk("latency", k, LAT);
        chk("latency_pos", position, 1);
        tick(10);
        pulse_clear();
        chk("clear_pos", position, 0);

        // 8 full forward Gray cycles
        repeat (32) step_fwd(20);
        chk("fwd_pos", position, 32);
        chk("fwd_dir", direction, 1);
        chk("fwd_err", error, 0);

        // reverse rotation, inverted then normal
        pulse_clear();
        invert_dir = 1'b1;
        repeat (12) step_rev(20);
        chk("rev_inv_pos", position, 12);
        chk("rev_inv_dir", direction, 1);
        pulse_clear();
        invert_dir = 1'b0;
        repeat (12) step_rev(20);
        chk("rev_pos", position, -12);
        chk("rev_dir", direction, 0);
        chk("rev_err", error, 0);

        // illegal transition 00 -> 11
        while (gidx != 0) step_fwd(20);
        chk("pre_illegal_pos", position, -9);
        gidx = 2;
        {enc_a, enc_b} = 2'b11;
        tick(20);
        chk("illegal_pos", position, -9);
        chk("illegal_err", error, 1);
        chk("illegal_dir", direction, 1);
        pulse_err_clear();
        chk("err_clear", error, 0);

        // illegal 11 -> 00 coinciding with err_clear: set wins
        gidx = 0;
        {enc_a, enc_b} = 2'b00;
        tick(LAT - 1);
        pulse_err_clear();
        chk("err_set_priority", error, 1);
        tick(5);
        pulse_err_clear();
        chk("err_clear2", error, 0);
        chk("illegal2_pos", position, -9);

`ifdef QDEC_FILTER_EN
        enc_a = 1'b1;
        tick(2);
        enc_a = 1'b0;
        tick(20);
        chk("glitch2_pos", position, -9);
        enc_a = 1'b1;
        tick(3);
        enc_a = 1'b0;
        tick(20);
        chk("glitch3_pos", position, -9);
        gidx = 3;
        enc_a = 1'b1;
        tick(20);
        chk("level_pos", position, -10);
        chk("level_dir", direction, 0);
`endif

        // velocity: 10 forward edges in one window
        tick(10);
        pulse_clear();
        chk("vel_clear_pos", position, 0);
        repeat (10) step_fwd(8);
        wait_vel(n);
        chk("win_len1", 80 + n, SC);
        chk("velocity10", velocity, 10);
        tick(1);
        chk("vel_valid_pulse", vel_valid, 0);

        // clear mid-window: only post-clear steps counted
        repeat (3) step_fwd(8);
        tick(4);
        pulse_clear();
        chk("mid_clear_pos", position, 0);
        repeat (5) step_fwd(8);
        wait_vel(n);
        chk("win_len2", 40 + n, SC);
        chk("velocity5", velocity, 5);
        chk("post_clear_pos", position, 5);

        // wrap at 8 bits
        tick(5);
        pulse_clear();
        repeat (127) step_fwd(6);
        chk("wrap_pre", position, 127);
        step_fwd(10);
        chk("wrap_pos", position, -128);
        chk("wrap_dir", direction, 1);

        // reset mid-rotation with pins at 11
        while (gidx != 2) step_fwd(10);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pos", position, 0);
        chk("async_rst_dir", direction, 1);
        tick(3);
        reset = 1'b0;
        tick(15);
        chk("reinit_pos", position, 0);
        chk("reinit_err", error, 0);
        step_fwd(20);
        chk("reinit_step_pos", position, 1);
        chk("reinit_step_err", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
